// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for regFile: after reset (or on a clear request) it
// zeroes registers 1..31, then shares the single write port between
// NUM_REQ requesters in round-robin order with a valid/ready handshake.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int N       = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_req_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*N-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      Reg_Write_o,
    output logic [ADDR_W-1:0]         Write_Register_o,
    output logic [N-1:0]              Write_Data_o,
    output logic                      init_done_o,
    output logic                      busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Highest register address; the clear sequence ends after writing it.
    localparam logic [ADDR_W-1:0] LAST_REG = '1;

    typedef enum logic {CLEAR, ARB} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [N-1:0]      data;
    } wr_req_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [N-1:0]        data_d;

    wr_req_t             req [NUM_REQ];
    logic [NUM_REQ-1:0]  gnt_vec;
    logic [PTR_W-1:0]    gnt_idx;
    logic                gnt_found;

    // Unpack the flattened per-requester address/data buses.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req[g] = {req_addr_i[g*ADDR_W +: ADDR_W], req_data_i[g*N +: N]};
    end

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int j;
        j         = 0;
        gnt_vec   = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid_i[j]) begin
                gnt_found  = 1'b1;
                gnt_idx    = PTR_W'(j);
                gnt_vec[j] = 1'b1;
            end
        end
    end

    // Ready only in ARB; a clear request blocks acceptance in the same cycle.
    assign req_ready_o = (state_q == ARB && !clear_req_i) ? gnt_vec : '0;
    assign init_done_o = (state_q == ARB);
    assign busy_o      = (state_q == CLEAR);

    // Next-state and next write-port values.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rr_ptr_d  = rr_ptr_q;
        we_d      = 1'b0;
        addr_d    = Write_Register_o;
        data_d    = Write_Data_o;
        case (state_q)
            CLEAR: begin
                we_d   = 1'b1;
                addr_d = clr_idx_q;
                data_d = '0;
                if (clr_idx_q == LAST_REG) begin
                    state_d   = ARB;
                    clr_idx_d = ADDR_W'(1);
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                end
            end
            ARB: begin
                if (clear_req_i) begin
                    state_d = CLEAR;
                end else if (gnt_found) begin
                    addr_d   = req[gnt_idx].addr;
                    data_d   = req[gnt_idx].data;
                    // Register 0 is hardwired; accept the request but suppress the write.
                    we_d     = |req[gnt_idx].addr;
                    rr_ptr_d = PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // State and registered write port; async reset restarts the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= CLEAR;
            clr_idx_q        <= ADDR_W'(1);
            rr_ptr_q         <= '0;
            Reg_Write_o      <= 1'b0;
            Write_Register_o <= '0;
            Write_Data_o     <= '0;
        end else begin
            state_q          <= state_d;
            clr_idx_q        <= clr_idx_d;
            rr_ptr_q         <= rr_ptr_d;
            Reg_Write_o      <= we_d;
            Write_Register_o <= addr_d;
            Write_Data_o     <= data_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear sequence, round-robin
// vectors, register-0 writes, clear request and mid-clear reset.
module tb_regfile_write_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear_req;
    logic [3:0]   valid;
    logic [19:0]  addr;
    logic [127:0] data;
    logic [3:0]   rdy;
    logic         we;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic         init_done;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Bench-side regFile: registers the write port like the real one.
    logic [31:0] rf [32] = '{default: 32'hdeadbeef};

    regfile_write_arbiter #(.NUM_REQ(4), .N(32), .ADDR_W(5)) dut (
        .clk              (clk),
        .reset            (rst_n),
        .clear_req_i      (clear_req),
        .req_valid_i      (valid),
        .req_addr_i       (addr),
        .req_data_i       (data),
        .req_ready_o      (rdy),
        .Reg_Write_o      (we),
        .Write_Register_o (waddr),
        .Write_Data_o     (wdata),
        .init_done_o      (init_done),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && we && waddr != 5'd0) rf[waddr] <= wdata;
    end

    // Requester protocol: a pending request keeps valid, address and data.
    logic [3:0]   pend;
    logic [19:0]  addr_q;
    logic [127:0] data_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i])
                    assert (valid[i] && addr[i*5 +: 5] == addr_q[i*5 +: 5] &&
                            data[i*32 +: 32] == data_q[i*32 +: 32])
                    else $error("requester %0d dropped or changed a pending request", i);
            end
            pend   <= valid & ~rdy;
            addr_q <= addr;
            data_q <= data;
        end
    end

    typedef struct {
        logic [3:0]   valid;
        logic [19:0]  addr;
        logic [127:0] data;
        logic [3:0]   rdy;
        logic         we;
        logic [4:0]   waddr;
        logic [31:0]  wdata;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] v,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [4:0] a3,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [3:0] r, input logic w,
                                input logic [4:0] wa, input logic [31:0] wd);
        vec_t t;
        t.valid = v;
        t.addr  = {a3, a2, a1, a0};
        t.data  = {d3, d2, d1, d0};
        t.rdy   = r;
        t.we    = w;
        t.waddr = wa;
        t.wdata = wd;
        return t;
    endfunction

    // Default requester set: addresses 2,4,25,31 with data 7,20,6,78.
    function automatic vec_t mka(input logic [3:0] v, input logic [3:0] r,
                                 input logic w, input logic [4:0] wa,
                                 input logic [31:0] wd);
        return mk(v, 5'd2, 5'd4, 5'd25, 5'd31, 32'd7, 32'd20, 32'd6, 32'd78, r, w, wa, wd);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Runs n clear writes from register 1, checking each edge.
    task automatic clear_run(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            chk($sformatf("%s ready%0d", tag, i), 32'(rdy), 32'd0);
            chk($sformatf("%s busy%0d", tag, i), 32'(busy), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("%s we%0d", tag, i), 32'(we), 32'd1);
            chk($sformatf("%s addr%0d", tag, i), 32'(waddr), 32'(i));
            chk($sformatf("%s data%0d", tag, i), wdata, 32'd0);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(4'b0100, 5'd2, 5'd4, 5'd4, 5'd31, 32'd7, 32'd20, 32'd20, 32'd78,
                      4'b0100, 1'b1, 5'd4, 32'd20);
        vecs[1]  = mka(4'b0000, 4'b0000, 1'b0, 5'd4,  32'd20);
        vecs[2]  = mka(4'b1000, 4'b1000, 1'b1, 5'd31, 32'd78);
        vecs[3]  = mka(4'b1111, 4'b0001, 1'b1, 5'd2,  32'd7);
        vecs[4]  = mka(4'b1111, 4'b0010, 1'b1, 5'd4,  32'd20);
        vecs[5]  = mka(4'b1111, 4'b0100, 1'b1, 5'd25, 32'd6);
        vecs[6]  = mka(4'b1111, 4'b1000, 1'b1, 5'd31, 32'd78);
        vecs[7]  = mka(4'b1111, 4'b0001, 1'b1, 5'd2,  32'd7);
        vecs[8]  = mka(4'b1111, 4'b0010, 1'b1, 5'd4,  32'd20);
        vecs[9]  = mka(4'b1111, 4'b0100, 1'b1, 5'd25, 32'd6);
        vecs[10] = mka(4'b1111, 4'b1000, 1'b1, 5'd31, 32'd78);
        vecs[11] = mka(4'b0111, 4'b0001, 1'b1, 5'd2,  32'd7);
        vecs[12] = mka(4'b0110, 4'b0010, 1'b1, 5'd4,  32'd20);
        vecs[13] = mka(4'b0100, 4'b0100, 1'b1, 5'd25, 32'd6);
        vecs[14] = mka(4'b0000, 4'b0000, 1'b0, 5'd25, 32'd6);
        vecs[15] = mk(4'b0010, 5'd2, 5'd0, 5'd25, 5'd31, 32'd7, 32'd3, 32'd6, 32'd78,
                      4'b0010, 1'b0, 5'd0, 32'd3);
        vecs[16] = mka(4'b1111, 4'b0100, 1'b1, 5'd25, 32'd6);
        vecs[17] = mka(4'b1011, 4'b1000, 1'b1, 5'd31, 32'd78);
        vecs[18] = mka(4'b0011, 4'b0001, 1'b1, 5'd2,  32'd7);
        vecs[19] = mka(4'b0010, 4'b0010, 1'b1, 5'd4,  32'd20);

        // Reset state, with all requesters asking.
        rst_n = 1'b0; clear_req = 1'b0; valid = 4'b1111; addr = '0; data = '0;
        #3;
        chk("rst we", 32'(we), 32'd0);
        chk("rst addr", 32'(waddr), 32'd0);
        chk("rst data", wdata, 32'd0);
        chk("rst init_done", 32'(init_done), 32'd0);
        chk("rst busy", 32'(busy), 32'd1);
        chk("rst ready", 32'(rdy), 32'd0);
        valid = 4'b0000;
        #9 rst_n = 1'b1;

        clear_run("clr", 31);
        chk("clr init_done", 32'(init_done), 32'd1);
        chk("clr busy", 32'(busy), 32'd0);

        // Arbitration vectors.
        for (int k = 0; k < NV; k++) begin
            valid = vecs[k].valid; addr = vecs[k].addr; data = vecs[k].data;
            #1;
            chk($sformatf("v%0d ready", k), 32'(rdy), 32'(vecs[k].rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d we", k), 32'(we), 32'(vecs[k].we));
            chk($sformatf("v%0d addr", k), 32'(waddr), 32'(vecs[k].waddr));
            chk($sformatf("v%0d data", k), wdata, vecs[k].wdata);
            if (k == 0) begin
                chk("rf1 cleared", rf[1], 32'd0);
                chk("rf17 cleared", rf[17], 32'd0);
                chk("rf31 cleared", rf[31], 32'd0);
            end
        end

        // Clear request while requester 0 waits.
        valid = 4'b0001;
        addr  = {5'd31, 5'd25, 5'd4, 5'd2};
        data  = {32'd78, 32'd6, 32'd20, 32'd99};
        clear_req = 1'b1;
        #1;
        chk("creq ready", 32'(rdy), 32'd0);
        @(posedge clk); #1;
        chk("creq we", 32'(we), 32'd0);
        chk("creq busy", 32'(busy), 32'd1);
        chk("creq init_done", 32'(init_done), 32'd0);
        chk("rf2 rr", rf[2], 32'd7);
        chk("rf4 rr", rf[4], 32'd20);
        chk("rf25 rr", rf[25], 32'd6);
        chk("rf31 rr", rf[31], 32'd78);
        clear_req = 1'b0;
        clear_run("reclr", 31);
        chk("reclr init_done", 32'(init_done), 32'd1);
        chk("rf2 zero", rf[2], 32'd0);
        chk("rf4 zero", rf[4], 32'd0);
        chk("rf25 zero", rf[25], 32'd0);
        chk("post ready", 32'(rdy), 32'd1);
        @(posedge clk); #1;
        chk("post we", 32'(we), 32'd1);
        chk("post addr", 32'(waddr), 32'd2);
        chk("post data", wdata, 32'd99);
        chk("rf31 zero", rf[31], 32'd0);
        valid = 4'b0000;
        @(posedge clk); #1;
        chk("idle we", 32'(we), 32'd0);
        chk("rf2 new", rf[2], 32'd99);

        // Reset ten writes into a clear sequence.
        clear_req = 1'b1;
        #1;
        chk("creq2 ready", 32'(rdy), 32'd0);
        @(posedge clk); #1;
        chk("creq2 we", 32'(we), 32'd0);
        clear_req = 1'b0;
        clear_run("mid", 10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst we", 32'(we), 32'd0);
        chk("arst addr", 32'(waddr), 32'd0);
        chk("arst data", wdata, 32'd0);
        chk("arst busy", 32'(busy), 32'd1);
        chk("arst init_done", 32'(init_done), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        clear_run("restart", 31);
        chk("restart init_done", 32'(init_done), 32'd1);
        chk("restart busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
